// File: rtl/hex_rotate_pkg.sv
// hex_rotate_pkg: shared types and helpers for the HEX display rotation controller
package hex_rotate_pkg;
    localparam int ROT_W = 2;
    typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} rot_state_t;
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;
    function automatic logic [ROT_W-1:0] rot_next(input logic [ROT_W-1:0] s, input logic d);
        return (d == DIR_REV) ? s - ROT_W'(1) : s + ROT_W'(1);
    endfunction
endpackage

// File: rtl/hex_rotate_ctrl_sync_edge.sv
// sync_edge: two-flop synchroniser followed by a rising-edge detector
module sync_edge (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic d,
    output logic q_edge
);
    logic s1_q, s2_q, prev_q;
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= d;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end
    assign q_edge = s2_q & ~prev_q;
endmodule

// File: rtl/hex_rotate_ctrl.sv
// hex_rotate_ctrl: prescaled auto-rotation of the HEX mux select with start/stop, direction and single-step
module hex_rotate_ctrl
    import hex_rotate_pkg::*;
#(
    parameter int DIV = 50000000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             dir,
    output logic [ROT_W-1:0] sel,
    output logic             tick,
    output logic             running
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic start_edge, stop_edge, step_edge;
    rot_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [ROT_W-1:0] sel_q, sel_d;
    logic tick_q, tick_d, adv;

    sync_edge u_start (.CLOCK_50(CLOCK_50), .reset(reset), .d(start), .q_edge(start_edge));
    sync_edge u_stop  (.CLOCK_50(CLOCK_50), .reset(reset), .d(stop),  .q_edge(stop_edge));
    sync_edge u_step  (.CLOCK_50(CLOCK_50), .reset(reset), .d(step),  .q_edge(step_edge));

    // A manual step overrides the prescaler; a stop edge freezes the count in place.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        adv     = 1'b0;
        if (stop_edge) state_d = STOPPED;
        else if (start_edge) state_d = RUNNING;
        if (step_edge) begin
            adv   = 1'b1;
            cnt_d = '0;
        end else if (state_q == STOPPED && state_d == RUNNING) begin
            cnt_d = '0;
        end else if (state_q == RUNNING && !stop_edge) begin
            adv    = (cnt_q == TERM);
            tick_d = adv;
            cnt_d  = adv ? '0 : cnt_q + CW'(1);
        end
        sel_d = adv ? rot_next(sel_q, dir) : sel_q;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= STOPPED;
            cnt_q   <= '0;
            sel_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
        end
    end

    assign sel     = sel_q;
    assign tick    = tick_q;
    assign running = (state_q == RUNNING);
endmodule

// File: tb/tb_hex_rotate_ctrl.sv
// tb_hex_rotate_ctrl: vector table, directed corner sequences and random traffic against an event-level model
module tb_hex_rotate_ctrl;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset, start, stop, step, dir;
    logic [1:0] sel;
    logic tick, running;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hex_rotate_ctrl #(.DIV(DIV)) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop), .step(step),
        .dir(dir), .sel(sel), .tick(tick), .running(running)
    );

    // Model: a button level seen at edge k acts at edge k+2 if it was low at edge k-1.
    logic [2:0] h_start, h_stop, h_step;
    int m_sel, m_cnt;
    logic m_run, m_tick;

    function automatic logic rose(input logic [2:0] h);
        return h[1] & ~h[2];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        h_start = '0; h_stop = '0; h_step = '0;
        m_sel = 0; m_cnt = 0; m_run = 1'b0; m_tick = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic sp, input logic sx, input logic d);
        logic se, pe, xe, adv;
        se = rose(h_start); pe = rose(h_stop); xe = rose(h_step);
        adv = 1'b0;
        m_tick = 1'b0;
        if (xe) begin
            adv = 1'b1;
            m_cnt = 0;
        end else if (!m_run && se && !pe) begin
            m_cnt = 0;
        end else if (m_run && !pe) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == DIV) begin
                m_cnt = 0;
                m_tick = 1'b1;
                adv = 1'b1;
            end
        end
        if (pe) m_run = 1'b0;
        else if (se) m_run = 1'b1;
        if (adv) m_sel = (m_sel + (d ? 3 : 1)) % 4;
        h_start = {h_start[1:0], st};
        h_stop  = {h_stop[1:0], sp};
        h_step  = {h_step[1:0], sx};
    endtask

    task automatic cyc(input logic st, input logic sp, input logic sx, input logic d);
        @(negedge clk);
        start = st; stop = sp; step = sx; dir = d;
        @(posedge clk);
        model_edge(st, sp, sx, d);
        #1;
        chk("sel", sel, m_sel);
        chk("tick", tick, m_tick);
        chk("running", running, m_run);
    endtask

    task automatic idle(input int n, input logic d);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic wait_tick();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * DIV && !seen; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            seen = tick;
        end
        chk("wait_tick", seen, 1);
    endtask

    typedef struct {
        logic st, sp, sx, d;
        int   sel;
        logic tk, run;
    } vec_t;
    vec_t vt[19];

    initial begin
        int base, tk_seen;
        vt[0]  = '{1, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 0, 0, 0, 0, 0, 1};
        vt[3]  = '{0, 0, 0, 0, 0, 0, 1};
        vt[4]  = '{0, 0, 0, 0, 0, 0, 1};
        vt[5]  = '{0, 0, 0, 0, 0, 0, 1};
        vt[6]  = '{0, 0, 0, 0, 1, 1, 1};
        vt[7]  = '{0, 0, 0, 0, 1, 0, 1};
        vt[8]  = '{0, 0, 0, 0, 1, 0, 1};
        vt[9]  = '{0, 0, 0, 0, 1, 0, 1};
        vt[10] = '{0, 0, 0, 0, 2, 1, 1};
        vt[11] = '{0, 0, 0, 0, 2, 0, 1};
        vt[12] = '{0, 0, 0, 0, 2, 0, 1};
        vt[13] = '{0, 0, 0, 0, 2, 0, 1};
        vt[14] = '{0, 0, 0, 0, 3, 1, 1};
        vt[15] = '{0, 0, 0, 0, 3, 0, 1};
        vt[16] = '{0, 0, 0, 0, 3, 0, 1};
        vt[17] = '{0, 0, 0, 0, 3, 0, 1};
        vt[18] = '{0, 0, 0, 0, 0, 1, 1};
        reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; dir = 1'b0;
        model_reset();
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_tick", tick, 0);
        chk("rst_running", running, 0);
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            cyc(vt[i].st, vt[i].sp, vt[i].sx, vt[i].d);
            chk("tbl_sel", sel, vt[i].sel);
            chk("tbl_tick", tick, vt[i].tk);
            chk("tbl_running", running, vt[i].run);
        end

        idle(4, 1'b1);
        chk("rev_3", sel, 3);
        idle(4, 1'b1);
        chk("rev_2", sel, 2);
        idle(2, 1'b1);
        idle(1, 1'b0);
        chk("dir_mid_no_tick", tick, 0);
        idle(1, 1'b0);
        chk("dir_mid_tick", tick, 1);
        chk("dir_mid_sel", sel, 3);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("stopped", running, 0);
        chk("stop_sel", sel, 3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b1);
        chk("step_rev_sel", sel, 2);
        tk_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            tk_seen += int'(tick);
        end
        idle(3, 1'b0);
        chk("hold_step_sel", sel, 3);
        chk("hold_step_ticks", tk_seen, 0);

        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(6, 1'b0);
        chk("startstop_stopped", running, 0);
        chk("startstop_sel", sel, 3);

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("restart", running, 1);
        wait_tick();
        base = m_sel;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("step_term_tick", tick, 0);
        chk("step_term_sel", sel, (base + 1) % 4);
        idle(3, 1'b0);
        chk("step_term_quiet", tick, 0);
        idle(1, 1'b0);
        chk("step_term_next_tick", tick, 1);
        chk("step_term_next_sel", sel, (base + 2) % 4);

        base = m_sel;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(8, 1'b0);
        chk("run_startstop_stopped", running, 0);
        chk("run_startstop_sel", sel, base);

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        wait_tick();
        idle(1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        #1 reset = 1'b1; step = 1'b0;
        model_reset();
        #1;
        chk("midrst_sel", sel, 0);
        chk("midrst_tick", tick, 0);
        chk("midrst_running", running, 0);
        @(posedge clk); #1 reset = 1'b0;
        idle(8, 1'b0);
        chk("post_rst_sel", sel, 0);
        chk("post_rst_running", running, 0);

        for (int i = 0; i < 400; i++)
            cyc(logic'($urandom_range(0, 11) == 0), logic'($urandom_range(0, 19) == 0),
                logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/hex_rotate_ctrl.md
Name: hex_rotate_ctrl

Overview:
- Timed rotation controller for the four-digit HEX character display.
- Generates the 2-bit rotation select that drives the select inputs of the 4-to-1 character multiplexers, which feed the 7-segment decoders.
- Replaces manual select-switch rotation with a prescaled automatic rotation, plus start/stop control, direction control and single-step from pushbuttons.

Parameters:
- DIV, 50000000, clock cycles per automatic rotation step; legal range DIV >= 2.
- CW, $clog2(DIV), prescaler counter width; derived, not overridden.

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  asynchronous level from a button; rising edge requests RUNNING.
- stop  in  1  asynchronous level; rising edge requests STOPPED.
- step  in  1  asynchronous level; rising edge requests one manual advance.
- dir  in  1  0 = forward (sel+1 mod 4), 1 = reverse (sel-1 mod 4); sampled at each advance.
- sel  out  2  rotation index to the mux select inputs.
- tick  out  1  one-cycle pulse on each automatic advance.
- running  out  1  high while FSM is in RUNNING.

Behaviour:
- Reset (async assert, synchronous-effect release):
  - sel = 0, tick = 0, running = 0.
  - prescaler cnt = 0, FSM = STOPPED, all synchroniser/edge flops = 0.
- Input conditioning, applied to start, stop and step:
  - 2-FF synchroniser (s1, s2), then prev flop; edge = s2 & ~prev.
  - Input first sampled high at edge k gives an edge pulse during the cycle after edge k+1. The action takes effect at edge k+2.
  - A held input yields exactly one edge pulse per press.
- FSM states: STOPPED, RUNNING.
  - STOPPED -> RUNNING on start_edge & ~stop_edge.
  - RUNNING -> STOPPED on stop_edge; stop wins if start_edge and stop_edge coincide.
  - Entering RUNNING clears cnt to 0. Entering STOPPED holds cnt.
  - running = (state == RUNNING), registered.
- Prescaler:
  - In RUNNING: if cnt == DIV-1, then cnt <= 0, tick <= 1, sel advances; else cnt <= cnt+1, tick <= 0.
  - In STOPPED: cnt holds, tick = 0.
  - First tick arrives DIV cycles after entering RUNNING.
- Manual step:
  - step_edge advances sel once in either state and clears cnt to 0.
  - tick does not assert for a manual step.
- Simultaneous step_edge and prescaler terminal count:
  - Exactly one advance, cnt <= 0, tick <= 0 (the step takes precedence).
- Simultaneous step_edge and stop_edge:
  - Both take effect: one advance, FSM -> STOPPED, cnt <= 0.
- Advance arithmetic:
  - 2-bit modular: forward 3 -> 0, reverse 0 -> 3.
  - dir is sampled combinationally at the advancing edge. A dir change mid-interval affects only the next advance and does not reset cnt.
- Reset mid-operation: all state returns to reset values immediately. An edge pending in the synchroniser is discarded.
- sel is registered, glitch-free, and changes only on advances.

Decomposition:
- Package hex_rotate_pkg:
  - ROT_W = 2.
  - typedef rot_state_t {STOPPED, RUNNING}.
  - constants DIR_FWD = 1'b0, DIR_REV = 1'b1.
- Sub-module sync_edge:
  - 2-FF synchroniser plus rising-edge detector.
  - Ports: CLOCK_50, reset, d, q_edge.
  - Instantiated three times (start, stop, step).
- Top contains the FSM, prescaler and sel register. Target about 150-250 lines total.

Test Plan:
- DIV=4. Reset, pulse start, dir=0 -> running=1 three edges after start is first sampled high; tick every 4 cycles; sel sequence 0,1,2,3,0.
- DIV=4, RUNNING, dir=1 from sel=0 -> sel 3,2,1,0. Change dir mid-interval -> cnt not reset; next advance uses the new dir.
- STOPPED, sel=2, hold step high 20 cycles -> sel = 3 exactly once, tick stays 0, cnt = 0.
- RUNNING, step edge arriving on the cycle cnt == DIV-1 -> sel advances by exactly 1, tick = 0, next tick DIV cycles later.
- start and stop pressed in the same cycle while STOPPED -> remains STOPPED. Same while RUNNING -> STOPPED, cnt frozen, sel unchanged.
- Assert reset mid-interval (cnt=2, sel=3, step pending in the synchroniser) -> sel = 0, tick = 0, running = 0 immediately. No advance after release.
